assert_ctrl_responder: RTL and testbench
========================================

Name: assert_ctrl_responder

Overview:
- Receiving end of the assertion-control command stream (on/off/kill, with level selection) issued by control blocks in this codebase.
- Holds a per-level assertion enable state.
- Runs one req/ack timeout checker per level; the enable state gates each checker.
- Reports failures as pulses plus a saturating total, so benches can observe control effects cycle-accurately.

Parameters:
- NUM_LEVELS, 4, number of assertion levels/checkers, each addressed by one bit of the level mask.
- TIMEOUT, 8, maximum cycles after chk_req in which chk_ack is accepted (must be >= 1).
- CNT_W, 8, width of fail_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  responder can accept a command
- cmd_op  input  2  00 nop, 01 on, 10 off, 11 kill
- cmd_levels  input  NUM_LEVELS  level mask the command applies to
- chk_req  input  NUM_LEVELS  per-level check start
- chk_ack  input  NUM_LEVELS  per-level response
- enabled  output  NUM_LEVELS  current per-level enable state
- fail_pulse  output  NUM_LEVELS  one-cycle failure indication per level
- fail_count  output  CNT_W  saturating total of failures
- busy  output  1  OR of all per-level pending states

Behaviour:
- Reset (async assert, values hold while rst=1):
  - enabled = all ones (assertions on by default).
  - cmd_ready=1, fail_pulse=0, fail_count=0, busy=0.
  - All checkers IDLE; control FSM READY.
- Command accept: cmd_valid && cmd_ready at a rising edge. Effect is visible on enabled the next cycle.
  - cmd_valid is ignored when cmd_ready=0; the sender holds it.
- Control FSM:
  - READY (cmd_ready=1): on accepted kill, go to FLUSH. All other ops stay in READY.
  - FLUSH (cmd_ready=0): lasts exactly 1 cycle, then READY. During FLUSH, chk_req is ignored on levels in the latched kill mask.
- Ops, applied to levels whose cmd_levels bit is 1; other levels are unchanged:
  - on: enabled bit set.
  - off: enabled bit cleared. Checks already PEND continue and can still fail.
  - kill: enabled bit cleared. PEND checkers go IDLE at the same edge, with no fail_pulse, even if that cycle was the timeout cycle.
  - nop: accepted, no effect.
- Per-level checker (states IDLE, PEND, counter width clog2(TIMEOUT+1)):
  - IDLE: if chk_req[i] && enabled[i], go to PEND with cnt=1. Use the registered enabled value, i.e. before any command accepted in the same cycle.
  - PEND, evaluated each cycle:
    - chk_ack[i] -> IDLE, no failure.
    - else cnt==TIMEOUT -> IDLE, and fail_pulse[i]=1 for the next cycle.
    - else cnt increments.
  - chk_req while PEND is ignored; there is no overlap.
  - chk_ack in the req cycle is ignored. With req at cycle 0, ack is accepted in cycles 1..TIMEOUT; a missing ack gives fail_pulse high in cycle TIMEOUT+1.
- fail_count:
  - Adds the popcount of failure events registered in the same cycle as fail_pulse.
  - Saturates at 2^CNT_W-1; never wraps.
- busy: registered, high whenever any checker is PEND.
- Reset mid-operation: all checkers abort immediately with no fail_pulse. Control returns to READY. enabled is restored to all ones.

Test Plan:
- After reset, chk_req[0]=1 at cycle 0, no ack -> fail_pulse[0] high in cycle 9 only (TIMEOUT=8); fail_count=1; busy high in cycles 1-8.
- chk_req[1] at cycle 0, chk_ack[1] at cycle 8 -> no fail_pulse, busy low from cycle 9. Ack at cycle 0 only -> failure in cycle 9.
- off on mask 4'b0001 while level 0 PEND -> pending check still fails at timeout. A later chk_req[0] does not start (busy stays 0). on 4'b0001 restores checking.
- kill 4'b0011 accepted in the same cycle level 0 would time out -> no fail_pulse; enabled=4'b1100; cmd_ready low for exactly one cycle; cmd_valid held meanwhile is accepted the cycle after.
- Command on 4'b0100 in the same cycle as chk_req[2], with level 2 disabled -> req ignored. chk_req[2] on the next cycle starts a check.
- CNT_W=2: five timeouts including two simultaneous -> fail_count reads 1,3,3 (saturated). Assert rst while 3 levels PEND -> all outputs at reset values asynchronously, no fail_pulse afterwards.

Source files
------------

// File: rtl/assert_ctrl_responder_if.sv
// Command and checker bus between an assertion-control sender and the responder.
interface assert_ctrl_responder_if #(
  parameter int NUM_LEVELS = 4,
  parameter int CNT_W      = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [NUM_LEVELS-1:0] cmd_levels;
  logic [NUM_LEVELS-1:0] chk_req;
  logic [NUM_LEVELS-1:0] chk_ack;
  logic [NUM_LEVELS-1:0] enabled;
  logic [NUM_LEVELS-1:0] fail_pulse;
  logic [CNT_W-1:0]      fail_count;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_op, cmd_levels, chk_req, chk_ack,
    input  cmd_ready, enabled, fail_pulse, fail_count, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_levels, chk_req, chk_ack,
    output cmd_ready, enabled, fail_pulse, fail_count, busy
  );
endinterface

// File: rtl/assert_ctrl_responder.sv
// Applies on/off/kill commands to per-level enables and runs one gated req/ack timeout checker per level.
// Commands take effect next cycle; cmd_ready drops for the single flush cycle after each accepted kill.
module assert_ctrl_responder #(
  parameter int NUM_LEVELS = 4,
  parameter int TIMEOUT    = 8,
  parameter int CNT_W      = 8
) (
  input logic                    clk,
  input logic                    rst,
  assert_ctrl_responder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(NUM_LEVELS + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ON   = 2'b01;
  localparam logic [1:0] OP_OFF  = 2'b10;
  localparam logic [1:0] OP_KILL = 2'b11;

  typedef enum logic {CTL_READY, CTL_FLUSH} ctl_state_t;
  typedef enum logic {CHK_IDLE, CHK_PEND} chk_state_t;

  ctl_state_t            ctl_q, ctl_d;
  logic [NUM_LEVELS-1:0] enabled_q, enabled_d;
  logic [NUM_LEVELS-1:0] kill_mask_q, kill_mask_d;
  logic                  cmd_fire;
  logic                  kill_fire;

  chk_state_t            chk_q [NUM_LEVELS];
  chk_state_t            chk_d [NUM_LEVELS];
  logic [TW-1:0]         cnt_q [NUM_LEVELS];
  logic [TW-1:0]         cnt_d [NUM_LEVELS];
  logic [NUM_LEVELS-1:0] req_block;
  logic [NUM_LEVELS-1:0] kill_now;
  logic [NUM_LEVELS-1:0] fail_ev;
  logic [NUM_LEVELS-1:0] fail_pulse_q;
  logic [PW-1:0]         fail_num;
  logic [SW-1:0]         count_sum;
  logic [CNT_W-1:0]      fail_count_q, fail_count_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q       <= CTL_READY;
      enabled_q   <= '1;
      kill_mask_q <= '0;
    end else begin
      ctl_q       <= ctl_d;
      enabled_q   <= enabled_d;
      kill_mask_q <= kill_mask_d;
    end
  end

  always_comb begin
    ctl_d       = ctl_q;
    enabled_d   = enabled_q;
    kill_mask_d = kill_mask_q;
    kill_fire   = 1'b0;
    cmd_fire    = bus.cmd_valid && (ctl_q == CTL_READY);
    case (ctl_q)
      CTL_READY: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OP_NOP:  ;
            OP_ON:   enabled_d = enabled_q | bus.cmd_levels;
            OP_OFF:  enabled_d = enabled_q & ~bus.cmd_levels;
            OP_KILL: begin
              enabled_d   = enabled_q & ~bus.cmd_levels;
              kill_mask_d = bus.cmd_levels;
              kill_fire   = 1'b1;
              ctl_d       = CTL_FLUSH;
            end
          endcase
        end
      end
      CTL_FLUSH: ctl_d = CTL_READY;
      default:   ctl_d = CTL_READY;
    endcase
  end

  assign req_block = (ctl_q == CTL_FLUSH) ? kill_mask_q : '0;
  assign kill_now  = kill_fire ? bus.cmd_levels : '0;

  // Kill wins over everything on its levels, including a timeout landing on the same edge.
  always_comb begin
    fail_ev = '0;
    busy_d  = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      chk_d[i] = chk_q[i];
      cnt_d[i] = cnt_q[i];
      if (kill_now[i]) begin
        chk_d[i] = CHK_IDLE;
      end else if (chk_q[i] == CHK_IDLE) begin
        if (bus.chk_req[i] && enabled_q[i] && !req_block[i]) begin
          chk_d[i] = CHK_PEND;
          cnt_d[i] = TW'(1);
        end
      end else if (bus.chk_ack[i]) begin
        chk_d[i] = CHK_IDLE;
      end else if (cnt_q[i] == TW'(TIMEOUT)) begin
        chk_d[i]   = CHK_IDLE;
        fail_ev[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + TW'(1);
      end
      if (chk_d[i] == CHK_PEND) busy_d = 1'b1;
    end
  end

  always_comb begin
    fail_num = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      fail_num = fail_num + PW'(fail_ev[i]);
    end
    count_sum    = SW'(fail_count_q) + SW'(fail_num);
    fail_count_d = (count_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : count_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        chk_q[i] <= CHK_IDLE;
        cnt_q[i] <= '0;
      end
      fail_pulse_q <= '0;
      fail_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        chk_q[i] <= chk_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      fail_pulse_q <= fail_ev;
      fail_count_q <= fail_count_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cmd_ready  = (ctl_q == CTL_READY);
  assign bus.enabled    = enabled_q;
  assign bus.fail_pulse = fail_pulse_q;
  assign bus.fail_count = fail_count_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_assert_ctrl_responder.sv
// Drives two responders (8-bit and 2-bit fail counters) with one stimulus stream and scoreboards them
// against a deadline-based model of the command and checker rules.
module tb_assert_ctrl_responder;
  localparam int NL = 4;
  localparam int TO = 8;
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_ON   = 2'd1;
  localparam logic [1:0] OP_OFF  = 2'd2;
  localparam logic [1:0] OP_KILL = 2'd3;

  logic clk;
  logic rst;

  assert_ctrl_responder_if #(.NUM_LEVELS(NL), .CNT_W(8)) ifa ();
  assert_ctrl_responder_if #(.NUM_LEVELS(NL), .CNT_W(2)) ifb ();

  assert_ctrl_responder #(.NUM_LEVELS(NL), .TIMEOUT(TO), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  assert_ctrl_responder #(.NUM_LEVELS(NL), .TIMEOUT(TO), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  assign ifb.cmd_valid  = ifa.cmd_valid;
  assign ifb.cmd_op     = ifa.cmd_op;
  assign ifb.cmd_levels = ifa.cmd_levels;
  assign ifb.chk_req    = ifa.chk_req;
  assign ifb.chk_ack    = ifa.chk_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] en;
    logic       rdy;
    logic [3:0] fp;
    logic       busy;
    logic [7:0] fca;
    logic [1:0] fcb;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  // Model: a check started at cycle s must be acked in s+1..s+TO, else it fails at s+TO.
  logic [3:0] m_en, m_kmask, m_pend, m_fp;
  logic       m_flush;
  int         m_start [4];
  int         m_fca, m_fcb, n;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 4'hf; m_kmask = 4'h0; m_pend = 4'h0; m_fp = 4'h0; m_flush = 1'b0;
    m_fca = 0; m_fcb = 0; n = 0;
    for (int i = 0; i < 4; i++) m_start[i] = 0;
  endtask

  task automatic cyc(input logic v, input logic [1:0] op, input logic [3:0] lv,
                     input logic [3:0] req, input logic [3:0] ack);
    exp_t       e;
    logic [3:0] nfp, npend;
    logic       acc;
    int         nf;
    ifa.cmd_valid = v; ifa.cmd_op = op; ifa.cmd_levels = lv;
    ifa.chk_req = req; ifa.chk_ack = ack;
    e.en = m_en; e.rdy = !m_flush; e.fp = m_fp; e.busy = |m_pend;
    e.fca = 8'(m_fca); e.fcb = 2'(m_fcb);
    exp_q.push_back(e);
    acc = v && !m_flush;
    nfp = 4'h0;
    npend = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i]) begin
        if (ack[i]) npend[i] = 1'b0;
        else if (n - m_start[i] == TO) begin npend[i] = 1'b0; nfp[i] = 1'b1; end
      end else if (req[i] && m_en[i] && !(m_flush && m_kmask[i])) begin
        npend[i] = 1'b1;
        m_start[i] = n;
      end
    end
    if (acc && op == OP_KILL) begin
      npend = npend & ~lv;
      nfp   = nfp & ~lv;
    end
    nf = $countones(nfp);
    m_fca = (m_fca + nf > 255) ? 255 : m_fca + nf;
    m_fcb = (m_fcb + nf > 3) ? 3 : m_fcb + nf;
    if (acc && op == OP_ON) m_en = m_en | lv;
    if (acc && (op == OP_OFF || op == OP_KILL)) m_en = m_en & ~lv;
    m_flush = acc && op == OP_KILL;
    m_kmask = lv;
    m_fp = nfp;
    m_pend = npend;
    n++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_enabled"}, int'(ifa.enabled), 'hf);
    chk({tag, "_ready"}, int'(ifa.cmd_ready), 1);
    chk({tag, "_fail_pulse"}, int'(ifa.fail_pulse), 0);
    chk({tag, "_fail_count"}, int'(ifa.fail_count), 0);
    chk({tag, "_fail_count_b"}, int'(ifb.fail_count), 0);
    chk({tag, "_busy"}, int'(ifa.busy), 0);
  endtask

  // Monitor: each sampled cycle consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enabled", int'(ifa.enabled), int'(e.en));
        chk("cmd_ready", int'(ifa.cmd_ready), int'(e.rdy));
        chk("fail_pulse", int'(ifa.fail_pulse), int'(e.fp));
        chk("busy", int'(ifa.busy), int'(e.busy));
        chk("fail_count", int'(ifa.fail_count), int'(e.fca));
        chk("enabled_b", int'(ifb.enabled), int'(e.en));
        chk("cmd_ready_b", int'(ifb.cmd_ready), int'(e.rdy));
        chk("fail_pulse_b", int'(ifb.fail_pulse), int'(e.fp));
        chk("busy_b", int'(ifb.busy), int'(e.busy));
        chk("fail_count_b", int'(ifb.fail_count), int'(e.fcb));
      end
    end
  end

  initial begin
    logic       hv;
    logic [1:0] hop;
    logic [3:0] hlv;
    logic [3:0] rq, ak;
    logic       was_ready;
    checks = 0; errors = 0;
    rst = 1'b0;
    ifa.cmd_valid = 1'b0; ifa.cmd_op = OP_NOP; ifa.cmd_levels = 4'h0;
    ifa.chk_req = 4'h0; ifa.chk_ack = 4'h0;
    model_reset();
    #2 rst = 1'b1;
    #1 check_reset_vals("init");
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;

    // Unacked check on level 0 fails in cycle 9.
    cyc(1'b0, OP_NOP, 4'h0, 4'b0001, 4'h0);
    chk("s1_busy_c1", int'(ifa.busy), 1);
    idle(8);
    chk("s1_pulse_c9", int'(ifa.fail_pulse), 'b0001);
    chk("s1_count", int'(ifa.fail_count), 1);
    chk("s1_busy_c9", int'(ifa.busy), 0);
    idle(1);
    chk("s1_pulse_c10", int'(ifa.fail_pulse), 0);

    // Ack on the last allowed cycle passes; an ack in the req cycle does not count.
    cyc(1'b0, OP_NOP, 4'h0, 4'b0010, 4'h0);
    idle(7);
    cyc(1'b0, OP_NOP, 4'h0, 4'h0, 4'b0010);
    chk("s2_busy", int'(ifa.busy), 0);
    chk("s2_pulse", int'(ifa.fail_pulse), 0);
    cyc(1'b0, OP_NOP, 4'h0, 4'b0010, 4'b0010);
    idle(8);
    chk("s2_early_ack", int'(ifa.fail_pulse), 'b0010);

    // Off leaves the pending check running, then blocks new ones until on.
    cyc(1'b0, OP_NOP, 4'h0, 4'b0001, 4'h0);
    idle(1);
    cyc(1'b1, OP_OFF, 4'b0001, 4'h0, 4'h0);
    idle(6);
    chk("s3_pulse", int'(ifa.fail_pulse), 'b0001);
    chk("s3_enabled", int'(ifa.enabled), 'b1110);
    cyc(1'b0, OP_NOP, 4'h0, 4'b0001, 4'h0);
    chk("s3_blocked", int'(ifa.busy), 0);
    cyc(1'b1, OP_ON, 4'b0001, 4'h0, 4'h0);
    cyc(1'b0, OP_NOP, 4'h0, 4'b0001, 4'h0);
    chk("s3_restart", int'(ifa.busy), 1);
    idle(8);
    chk("s3_pulse2", int'(ifa.fail_pulse), 'b0001);

    // Kill on the timeout cycle suppresses the failure; held command goes in after the flush.
    cyc(1'b0, OP_NOP, 4'h0, 4'b0001, 4'h0);
    idle(7);
    cyc(1'b1, OP_KILL, 4'b0011, 4'h0, 4'h0);
    chk("s4_pulse", int'(ifa.fail_pulse), 0);
    chk("s4_enabled", int'(ifa.enabled), 'b1100);
    chk("s4_ready_flush", int'(ifa.cmd_ready), 0);
    cyc(1'b1, OP_ON, 4'b0001, 4'b0011, 4'h0);
    chk("s4_ready_back", int'(ifa.cmd_ready), 1);
    chk("s4_not_taken", int'(ifa.enabled), 'b1100);
    chk("s4_busy", int'(ifa.busy), 0);
    cyc(1'b1, OP_ON, 4'b0001, 4'h0, 4'h0);
    chk("s4_taken", int'(ifa.enabled), 'b1101);

    // An on command does not enable a req in the same cycle.
    cyc(1'b1, OP_OFF, 4'b0100, 4'h0, 4'h0);
    cyc(1'b1, OP_ON, 4'b0100, 4'b0100, 4'h0);
    chk("s5_same_cycle", int'(ifa.busy), 0);
    cyc(1'b0, OP_NOP, 4'h0, 4'b0100, 4'h0);
    chk("s5_next_cycle", int'(ifa.busy), 1);
    idle(8);
    chk("s5_pulse", int'(ifa.fail_pulse), 'b0100);
    cyc(1'b1, OP_ON, 4'b1111, 4'h0, 4'h0);

    // Asynchronous reset with three checks pending.
    cyc(1'b1, OP_OFF, 4'b1000, 4'h0, 4'h0);
    cyc(1'b0, OP_NOP, 4'h0, 4'b0111, 4'h0);
    idle(3);
    rst = 1'b1;
    #1 check_reset_vals("mid");
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(12);

    // Saturation of the 2-bit counter: 1, 3, 3.
    cyc(1'b0, OP_NOP, 4'h0, 4'b0001, 4'h0);
    idle(8);
    chk("sat_b_1", int'(ifb.fail_count), 1);
    cyc(1'b0, OP_NOP, 4'h0, 4'b0110, 4'h0);
    idle(8);
    chk("sat_b_3", int'(ifb.fail_count), 3);
    chk("sat_a_3", int'(ifa.fail_count), 3);
    cyc(1'b0, OP_NOP, 4'h0, 4'b1001, 4'h0);
    idle(8);
    chk("sat_b_held", int'(ifb.fail_count), 3);
    chk("sat_a_5", int'(ifa.fail_count), 5);

    // Random traffic; a refused command is held until accepted.
    hv = 1'b0; hop = OP_NOP; hlv = 4'h0;
    for (int c = 0; c < 1500; c++) begin
      if (!hv && $urandom_range(0, 3) == 0) begin
        hv  = 1'b1;
        hop = 2'($urandom_range(0, 3));
        hlv = 4'($urandom);
      end
      rq = 4'($urandom) & 4'($urandom);
      ak = 4'($urandom) & 4'($urandom) & 4'($urandom);
      was_ready = !m_flush;
      cyc(hv, hop, hlv, rq, ak);
      if (hv && was_ready) hv = 1'b0;
    end
    idle(2);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
